// File: rtl/clk_freq_monitor.sv
// Measures mon_clk_i against clk: counts prescaled mon-clock toggles per window of clk cycles,
// classifies the count as slow/ok/fast, tracks a lock streak, and supplies a mon-domain reset.
`timescale 1ns/1ps
module clk_freq_monitor #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int MON_DIV       = 4,
    parameter int EXP_COUNT     = 320,
    parameter int TOLERANCE     = 4,
    parameter int LOCK_WINDOWS  = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             mon_clk_i,
    input  logic             enable_i,
    output logic             mon_rst_o,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             too_slow_o,
    output logic             too_fast_o,
    output logic             freq_ok_o,
    output logic             locked_o
);

    localparam int PRE_W = $clog2(MON_DIV);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int STK_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [PRE_W-1:0]        PRE_LAST    = PRE_W'(MON_DIV - 1);
    localparam logic [WIN_W-1:0]        WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [STK_W-1:0]        STK_MAX     = STK_W'(LOCK_WINDOWS);
    localparam logic [1:0]              SETTLE_LAST = 2'd3;
    localparam logic signed [CNT_W:0]   LO_BOUND    = (CNT_W+1)'(EXP_COUNT - TOLERANCE);
    localparam logic signed [CNT_W:0]   HI_BOUND    = (CNT_W+1)'(EXP_COUNT + TOLERANCE);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

    logic             r_mon_rst_q1, r_mon_rst_q2;
    logic [PRE_W-1:0] r_pre;
    logic             r_tgl;
    logic             r_sync1, r_sync2, r_sync3;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_settle;
    logic [WIN_W-1:0] r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic [STK_W-1:0] r_streak, w_streak_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_valid, r_slow, r_fast, r_ok, r_locked;
    logic             w_event;
    logic signed [CNT_W:0] w_cnt_s;
    logic             w_slow, w_fast, w_ok;

    // ---------------- mon_clk_i domain ----------------
    always_ff @(posedge mon_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mon_rst_q1 <= 1'b1;
            r_mon_rst_q2 <= 1'b1;
        end else begin
            r_mon_rst_q1 <= 1'b0;
            r_mon_rst_q2 <= r_mon_rst_q1;
        end
    end

    assign mon_rst_o = r_mon_rst_q2;

    always_ff @(posedge mon_clk_i or posedge r_mon_rst_q2) begin
        if (r_mon_rst_q2) begin
            r_pre <= '0;
            r_tgl <= 1'b0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_tgl <= ~r_tgl;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // ---------------- clk domain ----------------
    // Only the toggle flop crosses; its edges become single-cycle events.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= r_tgl;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_event = r_sync2 ^ r_sync3;

    assign w_cnt_s = {1'b0, r_cnt};
    assign w_slow  = (w_cnt_s < LO_BOUND);
    assign w_fast  = (w_cnt_s > HI_BOUND);
    assign w_ok    = !w_slow && !w_fast;

    always_comb begin
        w_streak_nxt = '0;
        if (w_ok)
            w_streak_nxt = (r_streak == STK_MAX) ? r_streak : r_streak + STK_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable_i) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (r_settle == SETTLE_LAST) w_state_nxt = S_MEASURE;
            S_MEASURE: if (r_timer == WIN_LAST) w_state_nxt = S_REPORT;
            S_REPORT:  w_state_nxt = S_MEASURE;
            default:   w_state_nxt = S_IDLE;
        endcase
        // Dropping enable aborts from any state, including the report cycle.
        if (!enable_i)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
            r_timer  <= '0;
            r_cnt    <= '0;
            r_streak <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_slow   <= 1'b0;
            r_fast   <= 1'b0;
            r_ok     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (!enable_i) begin
                r_streak <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_settle <= '0;
                    S_SETTLE: begin
                        r_settle <= r_settle + 2'd1;
                        r_timer  <= '0;
                        r_cnt    <= '0;
                    end
                    S_MEASURE: begin
                        r_timer <= r_timer + WIN_W'(1);
                        if (w_event && (r_cnt != {CNT_W{1'b1}}))
                            r_cnt <= r_cnt + CNT_W'(1);
                    end
                    S_REPORT: begin
                        r_count  <= r_cnt;
                        r_slow   <= w_slow;
                        r_fast   <= w_fast;
                        r_ok     <= w_ok;
                        r_valid  <= 1'b1;
                        r_streak <= w_streak_nxt;
                        r_locked <= (w_streak_nxt == STK_MAX);
                        r_timer  <= '0;
                        r_cnt    <= '0;
                    end
                    default: r_settle <= '0;
                endcase
            end
        end
    end

    assign count_o       = r_count;
    assign count_valid_o = r_valid;
    assign too_slow_o    = r_slow;
    assign too_fast_o    = r_fast;
    assign freq_ok_o     = r_ok;
    assign locked_o      = r_locked;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: directed frequency scenarios plus randomized mon-clock rates,
// checked against an ideal-rate count model and a window-level lock streak model.
`timescale 1ns/1ps
module tb_clk_freq_monitor;

    localparam int WINDOW  = 1024;
    localparam int SETTLE  = 4;
    localparam int EXP     = 320;
    localparam int TOL     = 4;
    localparam int LOCKN   = 3;
    localparam int MON_DIV = 4;
    localparam real CLK_PERIOD = 10.0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mon_clk_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        mon_rst_o;
    logic [15:0] count_o;
    logic        count_valid_o, too_slow_o, too_fast_o, freq_ok_o, locked_o;

    int  n_cmp = 0;
    int  n_err = 0;
    int  streak = 0;
    real mon_half = 4.0;
    bit  mon_run = 1'b1;

    clk_freq_monitor dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .mon_clk_i     (mon_clk_i),
        .enable_i      (enable_i),
        .mon_rst_o     (mon_rst_o),
        .count_o       (count_o),
        .count_valid_o (count_valid_o),
        .too_slow_o    (too_slow_o),
        .too_fast_o    (too_fast_o),
        .freq_ok_o     (freq_ok_o),
        .locked_o      (locked_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1.3;
        forever begin
            if (mon_run) #(mon_half) mon_clk_i = ~mon_clk_i;
            else #1;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ideal toggle events in one window for a mon clock with the given half period.
    function automatic int model_count(input real half);
        real t_win, t_evt;
        t_win = WINDOW * CLK_PERIOD;
        t_evt = 2.0 * half * MON_DIV;
        return int'(t_win / t_evt);
    endfunction

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!count_valid_o && n < 3000);
        if (!count_valid_o) check("pulse_timeout", 0, 1);
    endtask

    task automatic window(input string tag, input int exp_n, input int lo, input int hi);
        int n, c;
        bit es, ef, eo;
        wait_pulse(n);
        check({tag, "_period"}, n, exp_n);
        c  = int'(count_o);
        check({tag, "_cnt_in_range"}, (c >= lo && c <= hi), 1);
        es = (c < EXP - TOL);
        ef = (c > EXP + TOL);
        eo = !es && !ef;
        check({tag, "_too_slow"}, too_slow_o, es);
        check({tag, "_too_fast"}, too_fast_o, ef);
        check({tag, "_freq_ok"},  freq_ok_o,  eo);
        streak = eo ? ((streak < LOCKN) ? streak + 1 : LOCKN) : 0;
        check({tag, "_locked"}, locked_o, (streak == LOCKN));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    count_o, 0);
        check({tag, "_valid"},    count_valid_o, 0);
        check({tag, "_slow"},     too_slow_o, 0);
        check({tag, "_fast"},     too_fast_o, 0);
        check({tag, "_ok"},       freq_ok_o, 0);
        check({tag, "_locked"},   locked_o, 0);
        check({tag, "_mon_rst"},  mon_rst_o, 1);
    endtask

    initial begin
        int  m, k, held_cnt;
        bit  held_s, held_f, held_o, seen;
        real h;
        localparam int FIRST = SETTLE + WINDOW + 1;
        localparam int PERIOD = WINDOW + 1;

        // Reset state and mon-domain reset release
        #23;
        check_reset_outputs("rst");
        @(posedge clk); #1 rst_i = 1'b0;
        @(posedge mon_clk_i); #0.5;
        check("mon_rst_after_1_edge", mon_rst_o, 1);
        @(posedge mon_clk_i); #0.5;
        check("mon_rst_after_2_edges", mon_rst_o, 0);

        // 125 MHz: nominal, lock at third report
        @(posedge clk); #1 enable_i = 1'b1;
        @(posedge clk);
        m = model_count(4.0);
        window("f125_w1", FIRST,  m - 1, m + 1);
        window("f125_w2", PERIOD, m - 1, m + 1);
        window("f125_w3", PERIOD, m - 1, m + 1);
        check("f125_locked_third", locked_o, 1);

        // Monitored clock stops while locked
        mon_run = 1'b0;
        window("stopped", PERIOD, 0, 1);
        check("stopped_unlock", locked_o, 0);

        // 100 MHz: too slow
        mon_half = 5.0; mon_run = 1'b1;
        m = model_count(5.0);
        window("f100_lead", PERIOD, 0, 65535);
        window("f100_a", PERIOD, m - 1, m + 1);
        window("f100_b", PERIOD, m - 1, m + 1);
        check("f100_slow", too_slow_o, 1);

        // 150 MHz: too fast
        mon_half = 10.0 / 3.0;
        m = model_count(mon_half);
        window("f150_lead", PERIOD, 0, 65535);
        window("f150", PERIOD, m - 1, m + 1);
        check("f150_fast", too_fast_o, 1);

        // Random rates inside the valid range
        for (int i = 0; i < 3; i++) begin
            h = real'($urandom_range(2600, 6500)) / 1000.0;
            mon_half = h;
            m = model_count(h);
            window($sformatf("rand%0d_lead", i), PERIOD, 0, 65535);
            window($sformatf("rand%0d", i), PERIOD, m - 1, m + 1);
        end

        // Back to 125 MHz and relock
        mon_half = 4.0;
        m = model_count(4.0);
        window("relock_lead", PERIOD, 0, 65535);
        for (int i = 0; i < 3; i++)
            window($sformatf("relock%0d", i), PERIOD, m - 1, m + 1);
        check("relock_locked", locked_o, 1);

        // Enable dropped partway through a window
        held_cnt = int'(count_o);
        held_s = too_slow_o; held_f = too_fast_o; held_o = freq_ok_o;
        k = int'($urandom_range(450, 550));
        repeat (k) @(posedge clk);
        #1 enable_i = 1'b0;
        seen = 1'b0;
        repeat (1200) begin
            @(posedge clk); #1;
            if (count_valid_o) seen = 1'b1;
        end
        check("abort_no_pulse", seen, 0);
        check("abort_count_held", count_o, held_cnt);
        check("abort_slow_held", too_slow_o, held_s);
        check("abort_fast_held", too_fast_o, held_f);
        check("abort_ok_held", freq_ok_o, held_o);
        check("abort_unlocked", locked_o, 0);
        streak = 0;

        enable_i = 1'b1;
        @(posedge clk);
        window("reen_w1", FIRST,  m - 1, m + 1);
        window("reen_w2", PERIOD, m - 1, m + 1);

        // Reset pulsed mid-window with enable held high
        repeat (300) @(posedge clk);
        #1 rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        streak = 0;
        fork
            begin
                @(posedge mon_clk_i); #0.5;
                check("midrst_mon_rst_1_edge", mon_rst_o, 1);
                @(posedge mon_clk_i); #0.5;
                check("midrst_mon_rst_2_edges", mon_rst_o, 0);
            end
            begin
                @(posedge clk);
                window("post_rst", FIRST, m - 1, m + 1);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Consumer-side counterpart to the bench clock/reset generator: checks a generated or recovered clock (mon_clk_i) against the reference clock clk.
- Counts mon_clk_i activity over a fixed window of clk cycles and reports the count, fast/slow/ok status and a lock indication.
- Provides a reset synchronised into the mon_clk_i domain.
- Used in PCIe PHY benches and RTL to confirm a PLL/refclk is running at the expected rate before link training starts.

Parameters:
- WINDOW_CYCLES, 1024: clk cycles per measurement window (≥16).
- MON_DIV, 4: mon_clk_i prescale; power of two, ≥2. One toggle event per MON_DIV mon cycles.
- EXP_COUNT, 320: expected toggle events per window.
- TOLERANCE, 4: allowed absolute deviation from EXP_COUNT.
- LOCK_WINDOWS, 3: consecutive in-tolerance windows required to assert lock.
- CNT_W, 16: width of the count result.

Ports:
- clk, input, 1: reference clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- mon_clk_i, input, 1: monitored clock.
- enable_i, input, 1: run measurements while high.
- mon_rst_o, output, 1: rst_i synchronised to mon_clk_i. Asserts asynchronously; deasserts after 2 mon_clk_i rising edges.
- count_o, output, CNT_W: toggle events counted in the last completed window.
- count_valid_o, output, 1: one-cycle pulse when count_o updates.
- too_slow_o, output, 1: last window count < EXP_COUNT-TOLERANCE.
- too_fast_o, output, 1: last window count > EXP_COUNT+TOLERANCE.
- freq_ok_o, output, 1: last window count within tolerance, inclusive.
- locked_o, output, 1: LOCK_WINDOWS consecutive ok windows seen.

Behaviour:
- Reset values: all outputs 0, except mon_rst_o = 1. FSM in IDLE.
- Mon domain:
  - 2-flop reset synchroniser produces mon_rst_o.
  - While mon_rst_o is high, prescaler and toggle flop are held at 0.
  - Otherwise the prescaler counts mon_clk_i cycles modulo MON_DIV, and the toggle flop inverts when the prescaler wraps.
- Crossing to clk: toggle flop passes through a 3-flop synchroniser; an edge event is stage2 XOR stage3. No other signal crosses domains.
- Valid range: correct only while f_mon ≤ MON_DIV·f_clk/2. Above that, counts are undefined but must never exceed saturation.
- FSM states:
  - IDLE: wait for enable_i=1, then go to SETTLE.
  - SETTLE: 4 clk cycles. Edge events are ignored and synchroniser history is flushed. Then go to MEASURE with the window timer and edge counter cleared.
  - MEASURE: the edge counter increments on each event, saturating at 2^CNT_W-1. The window timer counts to WINDOW_CYCLES-1, then goes to REPORT. An event on the last cycle is counted.
  - REPORT: 1 cycle.
    - Load count_o and set status flags; exactly one of too_slow_o, freq_ok_o, too_fast_o is 1.
    - Pulse count_valid_o.
    - Update the lock streak and return to MEASURE (back-to-back windows, one dead cycle, whose event is not counted).
- Lock:
  - A streak counter saturates at LOCK_WINDOWS. It increments on an ok window and clears on a not-ok window.
  - locked_o = (streak == LOCK_WINDOWS) and is updated in the REPORT cycle.
- Comparison arithmetic: done at CNT_W+1 bits so EXP_COUNT-TOLERANCE < 0 does not wrap. A negative lower bound means too_slow_o is never set.
- enable_i low in any state (including REPORT):
  - Go to IDLE next cycle; the abort wins over window completion.
  - No count_valid_o pulse; the partial count is discarded.
  - Status flags and count_o are held; locked_o and the streak clear.
- rst_i mid-window: immediate return to reset values in both domains. The first window after release starts only after SETTLE.

Test Plan:
- clk 100 MHz, mon_clk_i 125 MHz, defaults, enable_i=1 after reset:
  - count_valid_o every 1025 clk cycles after SETTLE, count_o within 320±1, freq_ok_o=1.
  - locked_o rises at the 3rd REPORT.
- mon_clk_i 100 MHz: count_o 256±1, too_slow_o=1, freq_ok_o=0, locked_o stays 0.
- mon_clk_i 150 MHz: count_o 384±1, too_fast_o=1.
- Locked at 125 MHz, then mon_clk_i stopped: next completed window count_o ≤1, too_slow_o=1, locked_o falls in that REPORT cycle.
- enable_i dropped 500 cycles into a window:
  - No count_valid_o; prior count_o and flags held; locked_o=0.
  - Re-enable: first pulse 4+1024+1 cycles later.
- rst_i pulsed mid-window:
  - All outputs return to reset values immediately and mon_rst_o asserts.
  - mon_rst_o deasserts 2 mon_clk_i edges after release.
  - The count cycle after reset matches the scenario-1 timing.
